core_bus_arbiter: RTL and testbench

Two-master, one-slave arbiter that shares a single memory port between the core's instruction bus (master 0, ibus) and data bus (master 1, dbus). It uses the same req_valid/req_ready and rsp_valid/rsp_ready handshake as the core ports. It sits between the core and a single-ported memory or interconnect port. One transaction is outstanding at a time, and a response timeout prevents a dead slave from hanging the pipeline.

---
 rtl/core_bus_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_core_bus_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_bus_arbiter.sv
// core_bus_arbiter: shares one slave port between the ibus (master 0) and the dbus (master 1).
// Only one transaction is in flight at a time. A response watchdog can synthesize a zero-data
// response so that a dead slave cannot stall the core.
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   m{0,1}_addr/data/sel/we  master request fields
//   m{0,1}_req_valid_i/_o    master request handshake (req_ready_o)
//   m{0,1}_data_o/rsp_*      master response data and handshake
//   s_*                      slave request/response port
//   busy_o                   high whenever a transaction owns the slave port
//   timeout_o                one-cycle pulse when the response watchdog fires
module core_bus_arbiter #(
    parameter int unsigned ARB_MODE    = 0,  // 0: round-robin, 1: fixed priority (dbus wins)
    parameter int unsigned RSP_TIMEOUT = 0   // 0 disables the watchdog, max 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m0_data_i,
    input  logic [31:0] m1_data_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m0_we_i,
    input  logic        m1_we_i,
    input  logic        m0_req_valid_i,
    input  logic        m1_req_valid_i,
    output logic        m0_req_ready_o,
    output logic        m1_req_ready_o,
    output logic [31:0] m0_data_o,
    output logic [31:0] m1_data_o,
    output logic        m0_rsp_valid_o,
    output logic        m1_rsp_valid_o,
    input  logic        m0_rsp_ready_i,
    input  logic        m1_rsp_ready_i,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_data_o,
    output logic [3:0]  s_sel_o,
    output logic        s_we_o,
    output logic        s_req_valid_o,
    input  logic        s_req_ready_i,
    input  logic [31:0] s_data_i,
    input  logic        s_rsp_valid_i,
    output logic        s_rsp_ready_o,
    output logic        busy_o,
    output logic        timeout_o
);

    localparam logic [15:0] Timeout   = 16'(RSP_TIMEOUT);
    localparam bit          TimeoutEn = (RSP_TIMEOUT != 0);

    typedef enum logic [1:0] {StIdle, StReq, StRsp} state_e;

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic [15:0] cnt_q, cnt_d;
    // Set after the first timed-out cycle so the pulse fires once even if the owner stalls.
    logic        to_q, to_d;

    logic own_req_valid;
    logic own_rsp_ready;
    logic to_hit;
    logic rsp_timed;
    logic winner;

    assign own_req_valid = owner_q ? m1_req_valid_i : m0_req_valid_i;
    assign own_rsp_ready = owner_q ? m1_rsp_ready_i : m0_rsp_ready_i;
    assign to_hit        = TimeoutEn && (state_q == StRsp) && (cnt_q == Timeout);
    assign rsp_timed     = TimeoutEn && (state_q == StRsp) && (to_q || cnt_q == Timeout);
    assign timeout_o     = to_hit && !to_q;
    assign busy_o        = (state_q != StIdle);

    // Tie-break: fixed priority always picks the dbus, round-robin picks whoever lost last time.
    always_comb begin
        if (m0_req_valid_i && m1_req_valid_i) begin
            winner = (ARB_MODE == 32'd1) ? 1'b1 : ~last_q;
        end else begin
            winner = m1_req_valid_i;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        to_d    = to_q;
        case (state_q)
            StIdle: begin
                if (m0_req_valid_i || m1_req_valid_i) begin
                    owner_d = winner;
                    last_d  = winner;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (!own_req_valid) begin
                    state_d = StIdle;  // master withdrew before the slave took it
                end else if (s_req_ready_i) begin
                    state_d = StRsp;
                    cnt_d   = '0;
                    to_d    = 1'b0;
                end
            end
            StRsp: begin
                if (!s_rsp_valid_i && cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end
                if (rsp_timed) begin
                    to_d = 1'b1;
                    if (own_rsp_ready) begin
                        state_d = StIdle;
                    end
                end else if (s_rsp_valid_i && own_rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        m0_req_ready_o = 1'b0;
        m1_req_ready_o = 1'b0;
        m0_rsp_valid_o = 1'b0;
        m1_rsp_valid_o = 1'b0;
        m0_data_o      = '0;
        m1_data_o      = '0;
        s_addr_o       = '0;
        s_data_o       = '0;
        s_sel_o        = '0;
        s_we_o         = 1'b0;
        s_req_valid_o  = 1'b0;
        s_rsp_ready_o  = 1'b0;
        case (state_q)
            StReq: begin
                s_req_valid_o = own_req_valid;
                if (owner_q) begin
                    s_addr_o       = m1_addr_i;
                    s_data_o       = m1_data_i;
                    s_sel_o        = m1_sel_i;
                    s_we_o         = m1_we_i;
                    m1_req_ready_o = s_req_ready_i;
                end else begin
                    s_addr_o       = m0_addr_i;
                    s_data_o       = m0_data_i;
                    s_sel_o        = m0_sel_i;
                    s_we_o         = m0_we_i;
                    m0_req_ready_o = s_req_ready_i;
                end
            end
            StRsp: begin
                if (rsp_timed) begin
                    // Synthesized zero-data response; the slave is not acknowledged.
                    if (owner_q) begin
                        m1_rsp_valid_o = 1'b1;
                    end else begin
                        m0_rsp_valid_o = 1'b1;
                    end
                end else begin
                    s_rsp_ready_o = own_rsp_ready;
                    if (owner_q) begin
                        m1_rsp_valid_o = s_rsp_valid_i;
                        m1_data_o      = s_data_i;
                    end else begin
                        m0_rsp_valid_o = s_rsp_valid_i;
                        m0_data_o      = s_data_i;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
        end
    end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Bench for core_bus_arbiter. Two instances share one stimulus stream:
//   instance 0: round-robin, response watchdog of 8 cycles
//   instance 1: fixed priority, watchdog disabled
// Each instance is compared every cycle against a transaction-level reference model.
module tb_core_bus_arbiter;

    logic        clk;
    logic        rst;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, s_rdata;
    logic [3:0]  m0_sel, m1_sel;
    logic        m0_we, m1_we, m0_req_valid, m1_req_valid, m0_rsp_ready, m1_rsp_ready;
    logic        s_req_ready, s_rsp_valid;

    logic        o_m0_req_ready [2];
    logic        o_m1_req_ready [2];
    logic [31:0] o_m0_data      [2];
    logic [31:0] o_m1_data      [2];
    logic        o_m0_rsp_valid [2];
    logic        o_m1_rsp_valid [2];
    logic [31:0] o_s_addr       [2];
    logic [31:0] o_s_data       [2];
    logic [3:0]  o_s_sel        [2];
    logic        o_s_we         [2];
    logic        o_s_req_valid  [2];
    logic        o_s_rsp_ready  [2];
    logic        o_busy         [2];
    logic        o_timeout      [2];

    core_bus_arbiter #(.ARB_MODE(0), .RSP_TIMEOUT(8)) u_dut_rr (
        .clk(clk), .rst(rst),
        .m0_addr_i(m0_addr), .m1_addr_i(m1_addr), .m0_data_i(m0_wdata), .m1_data_i(m1_wdata),
        .m0_sel_i(m0_sel), .m1_sel_i(m1_sel), .m0_we_i(m0_we), .m1_we_i(m1_we),
        .m0_req_valid_i(m0_req_valid), .m1_req_valid_i(m1_req_valid),
        .m0_req_ready_o(o_m0_req_ready[0]), .m1_req_ready_o(o_m1_req_ready[0]),
        .m0_data_o(o_m0_data[0]), .m1_data_o(o_m1_data[0]),
        .m0_rsp_valid_o(o_m0_rsp_valid[0]), .m1_rsp_valid_o(o_m1_rsp_valid[0]),
        .m0_rsp_ready_i(m0_rsp_ready), .m1_rsp_ready_i(m1_rsp_ready),
        .s_addr_o(o_s_addr[0]), .s_data_o(o_s_data[0]), .s_sel_o(o_s_sel[0]), .s_we_o(o_s_we[0]),
        .s_req_valid_o(o_s_req_valid[0]), .s_req_ready_i(s_req_ready), .s_data_i(s_rdata),
        .s_rsp_valid_i(s_rsp_valid), .s_rsp_ready_o(o_s_rsp_ready[0]),
        .busy_o(o_busy[0]), .timeout_o(o_timeout[0])
    );

    core_bus_arbiter #(.ARB_MODE(1), .RSP_TIMEOUT(0)) u_dut_fp (
        .clk(clk), .rst(rst),
        .m0_addr_i(m0_addr), .m1_addr_i(m1_addr), .m0_data_i(m0_wdata), .m1_data_i(m1_wdata),
        .m0_sel_i(m0_sel), .m1_sel_i(m1_sel), .m0_we_i(m0_we), .m1_we_i(m1_we),
        .m0_req_valid_i(m0_req_valid), .m1_req_valid_i(m1_req_valid),
        .m0_req_ready_o(o_m0_req_ready[1]), .m1_req_ready_o(o_m1_req_ready[1]),
        .m0_data_o(o_m0_data[1]), .m1_data_o(o_m1_data[1]),
        .m0_rsp_valid_o(o_m0_rsp_valid[1]), .m1_rsp_valid_o(o_m1_rsp_valid[1]),
        .m0_rsp_ready_i(m0_rsp_ready), .m1_rsp_ready_i(m1_rsp_ready),
        .s_addr_o(o_s_addr[1]), .s_data_o(o_s_data[1]), .s_sel_o(o_s_sel[1]), .s_we_o(o_s_we[1]),
        .s_req_valid_o(o_s_req_valid[1]), .s_req_ready_i(s_req_ready), .s_data_i(s_rdata),
        .s_rsp_valid_i(s_rsp_valid), .s_rsp_ready_o(o_s_rsp_ready[1]),
        .busy_o(o_busy[1]), .timeout_o(o_timeout[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference model: a transaction is "granted" (busy), then "accepted" by the slave, then
    // waits for a response; wait counts response cycles without slave data.
    bit mdl_busy  [2];
    bit mdl_acc   [2];
    bit mdl_who   [2];
    bit mdl_last  [2];
    int mdl_wait  [2];
    int mdl_tocyc [2];

    function automatic int tmo(input int k);
        return (k == 0) ? 8 : 0;
    endfunction

    function automatic bit timed(input int k);
        return mdl_busy[k] && mdl_acc[k] && tmo(k) != 0 && mdl_wait[k] >= tmo(k);
    endfunction

    task automatic mdl_step(input int k);
        bit w;
        bit rv;
        bit rr;
        if (rst) begin
            mdl_busy[k] = 0;
            mdl_acc[k]  = 0;
            mdl_last[k] = 0;
        end else if (!mdl_busy[k]) begin
            if (m0_req_valid || m1_req_valid) begin
                if (m0_req_valid && m1_req_valid) w = (k == 1) ? 1'b1 : !mdl_last[k];
                else w = m1_req_valid;
                mdl_who[k]  = w;
                mdl_last[k] = w;
                mdl_busy[k] = 1;
                mdl_acc[k]  = 0;
            end
        end else if (!mdl_acc[k]) begin
            rv = mdl_who[k] ? m1_req_valid : m0_req_valid;
            if (!rv) begin
                mdl_busy[k] = 0;
            end else if (s_req_ready) begin
                mdl_acc[k]   = 1;
                mdl_wait[k]  = 0;
                mdl_tocyc[k] = 0;
            end
        end else begin
            rr = mdl_who[k] ? m1_rsp_ready : m0_rsp_ready;
            if (timed(k)) begin
                mdl_tocyc[k]++;
                if (rr) mdl_busy[k] = 0;
            end else if (s_rsp_valid && rr) begin
                mdl_busy[k] = 0;
            end else if (!s_rsp_valid) begin
                mdl_wait[k]++;
            end
        end
    endtask

    task automatic mdl_expect(input int k, output logic [63:0] em0, output logic [63:0] em1,
                              output logic [63:0] esa, output logic [63:0] esc,
                              output logic [63:0] est);
        logic [63:0] own;
        own = '0;
        esa = '0;
        esc = '0;
        est = {62'b0, mdl_busy[k], timed(k) && mdl_tocyc[k] == 0};
        if (mdl_busy[k] && !mdl_acc[k]) begin
            own = {30'b0, s_req_ready, 1'b0, 32'b0};
            if (mdl_who[k]) begin
                esa = {32'b0, m1_addr};
                esc = {25'b0, m1_wdata, m1_sel, m1_we, m1_req_valid, 1'b0};
            end else begin
                esa = {32'b0, m0_addr};
                esc = {25'b0, m0_wdata, m0_sel, m0_we, m0_req_valid, 1'b0};
            end
        end else if (mdl_busy[k] && mdl_acc[k]) begin
            if (timed(k)) begin
                own = {30'b0, 1'b0, 1'b1, 32'b0};
            end else begin
                own = {30'b0, 1'b0, s_rsp_valid, s_rdata};
                esc = {63'b0, mdl_who[k] ? m1_rsp_ready : m0_rsp_ready};
            end
        end
        em0 = (mdl_busy[k] && !mdl_who[k]) ? own : 64'b0;
        em1 = (mdl_busy[k] && mdl_who[k]) ? own : 64'b0;
    endtask

    task automatic check_all();
        logic [63:0] e0, e1, ea, ec, es;
        for (int k = 0; k < 2; k++) begin
            mdl_expect(k, e0, e1, ea, ec, es);
            check_val($sformatf("m0[%0d]", k),
                      {30'b0, o_m0_req_ready[k], o_m0_rsp_valid[k], o_m0_data[k]}, e0);
            check_val($sformatf("m1[%0d]", k),
                      {30'b0, o_m1_req_ready[k], o_m1_rsp_valid[k], o_m1_data[k]}, e1);
            check_val($sformatf("s_addr[%0d]", k), {32'b0, o_s_addr[k]}, ea);
            check_val($sformatf("s_ctl[%0d]", k),
                      {25'b0, o_s_data[k], o_s_sel[k], o_s_we[k], o_s_req_valid[k],
                       o_s_rsp_ready[k]}, ec);
            check_val($sformatf("status[%0d]", k), {62'b0, o_busy[k], o_timeout[k]}, es);
        end
    endtask

    // Clock edge: advance the model with the inputs the DUT just sampled.
    task automatic adv();
        @(posedge clk);
        mdl_step(0);
        mdl_step(1);
        #1;
    endtask

    task automatic chk();
        @(negedge clk);
        check_all();
    endtask

    int unsigned p_req, p_hold, p_mrdy, p_sready, p_srsp;

    task automatic drive_rand();
        // Request fields may only change while the master is not holding a request.
        if (!m0_req_valid) begin
            m0_addr  = $urandom;
            m0_wdata = $urandom;
            m0_sel   = 4'($urandom);
            m0_we    = 1'($urandom);
        end
        if (!m1_req_valid) begin
            m1_addr  = $urandom;
            m1_wdata = $urandom;
            m1_sel   = 4'($urandom);
            m1_we    = 1'($urandom);
        end
        m0_req_valid = m0_req_valid ? ($urandom_range(99) < p_hold) : ($urandom_range(99) < p_req);
        m1_req_valid = m1_req_valid ? ($urandom_range(99) < p_hold) : ($urandom_range(99) < p_req);
        m0_rsp_ready = ($urandom_range(99) < p_mrdy);
        m1_rsp_ready = ($urandom_range(99) < p_mrdy);
        s_req_ready  = ($urandom_range(99) < p_sready);
        s_rsp_valid  = ($urandom_range(99) < p_srsp);
        s_rdata      = $urandom;
        rst          = ($urandom_range(199) == 0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0; s_rdata = '0;
        m0_sel = '0; m1_sel = '0; m0_we = 1'b0; m1_we = 1'b0;
        m0_req_valid = 1'b0; m1_req_valid = 1'b0; m0_rsp_ready = 1'b0; m1_rsp_ready = 1'b0;
        s_req_ready = 1'b0; s_rsp_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mdl_busy[k] = 0; mdl_acc[k] = 0; mdl_who[k] = 0; mdl_last[k] = 0;
            mdl_wait[k] = 0; mdl_tocyc[k] = 0;
        end
        adv();
        adv();

        // Single ibus read: idle cycle 0, slave request cycle 1, response cycle 2, idle cycle 3.
        rst          = 1'b0;
        m0_req_valid = 1'b1;
        m0_addr      = 32'h100;
        m0_sel       = 4'hF;
        s_req_ready  = 1'b1;
        m0_rsp_ready = 1'b1;
        chk();
        check_val("rst_busy", {63'b0, o_busy[0]}, 64'd0);
        adv();
        chk();
        check_val("dir_saddr", {32'b0, o_s_addr[0]}, 64'h100);
        adv();
        m0_req_valid = 1'b0;
        s_rsp_valid  = 1'b1;
        s_rdata      = 32'h1234_5678;
        chk();
        check_val("dir_rsp", {31'b0, o_m0_rsp_valid[0], o_m0_data[0]}, 64'h1_1234_5678);
        adv();
        s_rsp_valid = 1'b0;
        chk();
        check_val("dir_busy", {63'b0, o_busy[0]}, 64'd0);

        // Randomized segments, each with its own traffic/slave profile (incl. a dead slave).
        for (int seg = 0; seg < 40; seg++) begin
            p_req    = ($urandom_range(1) == 0) ? 25 : 100;
            p_hold   = ($urandom_range(1) == 0) ? 85 : 100;
            p_mrdy   = ($urandom_range(1) == 0) ? 50 : 100;
            p_sready = ($urandom_range(1) == 0) ? 30 : 100;
            case ($urandom_range(2))
                0: p_srsp = 0;
                1: p_srsp = 30;
                default: p_srsp = 100;
            endcase
            for (int c = 0; c < 50; c++) begin
                adv();
                drive_rand();
                chk();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
